proc_hazard_unit: RTL and testbench

Parametrised hazard and pipeline-tracking controller for the TinyRV1 in-order pipeline (F, D, then NSTAGES execution/write-back stages). It decodes the D-stage instruction and keeps a shift register of in-flight destination records. From these it generates the stall, squash and bypass-select controls and the W-stage register-file write controls. It sits between the instruction port and the datapath, replacing fixed-depth hazard logic with depth-, load-latency- and multiply-latency-configurable logic.

---
 rtl/proc_hazard_unit.sv | 205 ++++++++++++++++++++
 tb/tb_proc_hazard_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_hazard_unit.sv
// proc_hazard_unit: hazard and pipeline-tracking controller for the TinyRV1
// in-order pipeline (F, D, then NSTAGES execution/write-back stages).
// Decodes the D instruction, tracks in-flight destination records and
// produces stall, squash, bypass-select and W-stage write controls.
// Optional feature macro: PROC_HAZARD_MUL_STALL_EN (multi-cycle MUL in X).
module proc_hazard_unit #(
    parameter int NSTAGES  = 3,
    parameter int LW_STAGE = 1,
    parameter int MUL_LAT  = 3,
    parameter int SELW     = $clog2(NSTAGES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_D,
    input  logic            eq_X,
    output logic            stall_F,
    output logic            stall_D,
    output logic            stall_X,
    output logic            squash_F,
    output logic            squash_D,
    output logic [SELW-1:0] op1_byp_sel_D,
    output logic [SELW-1:0] op2_byp_sel_D,
    output logic            rf_wen_W,
    output logic [4:0]      rf_waddr_W
);

    typedef struct packed {
        logic       val;
        logic       wen;
        logic [4:0] rd;
        logic       is_lw;
        logic       is_mul;
        logic       is_bne;
    } rec_t;

    rec_t stage_r [NSTAGES];
    logic val_D_r;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [4:0] rd_s;
    logic is_add_s, is_addi_s, is_mul_s, is_lw_s, is_sw_s, is_jal_s, is_jr_s, is_bne_s;
    logic reads_rs1_s, reads_rs2_s, writes_s;

    logic taken_X_s, squash_D_s, squash_F_s, stall_D_s, stall_X_s, load_use_s, d_live_s;
    logic [NSTAGES-1:0] hit1_s, hit2_s, rdy_s, lu_s;
    logic [SELW-1:0] sel1_s, sel2_s;
    rec_t d_rec_s;

    // Decode the D-stage instruction into its class and register fields.
    always_comb begin
        opcode_s    = inst_D[6:0];
        funct3_s    = inst_D[14:12];
        funct7_s    = inst_D[31:25];
        rs1_s       = inst_D[19:15];
        rs2_s       = inst_D[24:20];
        rd_s        = inst_D[11:7];
        is_add_s    = (opcode_s == 7'b0110011) && (funct3_s == 3'b000) && (funct7_s == 7'b0000000);
        is_mul_s    = (opcode_s == 7'b0110011) && (funct3_s == 3'b000) && (funct7_s == 7'b0000001);
        is_addi_s   = (opcode_s == 7'b0010011) && (funct3_s == 3'b000);
        is_lw_s     = (opcode_s == 7'b0000011) && (funct3_s == 3'b010);
        is_sw_s     = (opcode_s == 7'b0100011) && (funct3_s == 3'b010);
        is_jal_s    = (opcode_s == 7'b1101111);
        is_jr_s     = (opcode_s == 7'b1100111) && (funct3_s == 3'b000) &&
                      (rd_s == 5'd0) && (inst_D[31:20] == 12'd0);
        is_bne_s    = (opcode_s == 7'b1100011) && (funct3_s == 3'b001);
        reads_rs1_s = is_add_s | is_addi_s | is_mul_s | is_lw_s | is_sw_s | is_jr_s | is_bne_s;
        reads_rs2_s = is_add_s | is_mul_s | is_sw_s | is_bne_s;
        writes_s    = is_add_s | is_addi_s | is_mul_s | is_lw_s | is_jal_s;
    end

`ifdef PROC_HAZARD_MUL_STALL_EN
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);
    logic [3:0] mul_cnt_r;

    // A MUL holds X until its counter reaches the last latency cycle.
    always_comb begin
        stall_X_s = stage_r[0].val & stage_r[0].is_mul & (mul_cnt_r != MUL_LAST);
    end

    // Count cycles the MUL has been held in X; clear once it moves on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt_r <= 4'd0;
        end else if (stall_X_s) begin
            mul_cnt_r <= mul_cnt_r + 4'd1;
        end else begin
            mul_cnt_r <= 4'd0;
        end
    end
`else
    // Without the multi-cycle MUL, X never holds.
    always_comb begin
        stall_X_s = 1'b0;
    end
`endif

    // Per-stage source matches, result readiness and load-use detection.
    always_comb begin
        hit1_s = '0;
        hit2_s = '0;
        rdy_s  = '0;
        lu_s   = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            hit1_s[k] = val_D_r & reads_rs1_s & stage_r[k].val & stage_r[k].wen &
                        (stage_r[k].rd == rs1_s) & (stage_r[k].rd != 5'd0);
            hit2_s[k] = val_D_r & reads_rs2_s & stage_r[k].val & stage_r[k].wen &
                        (stage_r[k].rd == rs2_s) & (stage_r[k].rd != 5'd0);
            // Loads are not ready before LW_STAGE; a held MUL is not ready in X.
            rdy_s[k]  = ~(stage_r[k].is_lw & (k < LW_STAGE)) &
                        ~((k == 0) & stage_r[k].is_mul & stall_X_s);
            lu_s[k]   = (hit1_s[k] | hit2_s[k]) & stage_r[k].is_lw & (k < LW_STAGE);
        end
    end

    // Pick the youngest matching stage with a ready result for each operand.
    always_comb begin
        sel1_s = '0;
        sel2_s = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (hit1_s[k] & rdy_s[k]) begin
                sel1_s = SELW'(k + 1);
            end else begin
                sel1_s = sel1_s;
            end
            if (hit2_s[k] & rdy_s[k]) begin
                sel2_s = SELW'(k + 1);
            end else begin
                sel2_s = sel2_s;
            end
        end
    end

    // Branch resolution, squash and stall generation; squash wins over stall.
    always_comb begin
        load_use_s = |lu_s;
        taken_X_s  = stage_r[0].val & stage_r[0].is_bne & ~eq_X;
        squash_D_s = taken_X_s;
        stall_D_s  = val_D_r & ~squash_D_s & (load_use_s | stall_X_s);
        squash_F_s = taken_X_s | (val_D_r & (is_jal_s | is_jr_s) & ~stall_D_s);
        d_live_s   = val_D_r & ~squash_D_s & ~stall_D_s;
    end

    // Record entering X; a bubble carries an all-zero record.
    always_comb begin
        d_rec_s = '0;
        if (d_live_s) begin
            d_rec_s.val    = 1'b1;
            d_rec_s.wen    = writes_s;
            d_rec_s.rd     = writes_s ? rd_s : 5'd0;
            d_rec_s.is_lw  = is_lw_s;
            d_rec_s.is_mul = is_mul_s;
            d_rec_s.is_bne = is_bne_s;
        end else begin
            d_rec_s = '0;
        end
    end

    // D valid bit: cleared by an F squash, held while F is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_D_r <= 1'b0;
        end else if (stall_F) begin
            val_D_r <= val_D_r;
        end else begin
            val_D_r <= ~squash_F_s;
        end
    end

    // Shift in-flight records down the pipe; X holds and stage 1 bubbles on stall_X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NSTAGES; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            if (stall_X_s) begin
                stage_r[0] <= stage_r[0];
            end else begin
                stage_r[0] <= d_rec_s;
            end
            for (int k = 1; k < NSTAGES; k++) begin
                if ((k == 1) && stall_X_s) begin
                    stage_r[k] <= '0;
                end else begin
                    stage_r[k] <= stage_r[k-1];
                end
            end
        end
    end

    assign stall_F       = stall_D_s;
    assign stall_D       = stall_D_s;
    assign stall_X       = stall_X_s;
    assign squash_F      = squash_F_s;
    assign squash_D      = squash_D_s;
    assign op1_byp_sel_D = sel1_s;
    assign op2_byp_sel_D = sel2_s;
    assign rf_wen_W      = stage_r[NSTAGES-1].val & stage_r[NSTAGES-1].wen;
    assign rf_waddr_W    = stage_r[NSTAGES-1].rd;

endmodule

// File: tb/tb_proc_hazard_unit.sv
// Directed self-checking bench for proc_hazard_unit (default parameters).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_proc_hazard_unit;

    logic        clk;
    logic        rst;
    logic [31:0] inst_D;
    logic        eq_X;
    logic        stall_F, stall_D, stall_X, squash_F, squash_D;
    logic [1:0]  op1_byp_sel_D, op2_byp_sel_D;
    logic        rf_wen_W;
    logic [4:0]  rf_waddr_W;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    proc_hazard_unit dut (
        .clk           (clk),
        .rst           (rst),
        .inst_D        (inst_D),
        .eq_X          (eq_X),
        .stall_F       (stall_F),
        .stall_D       (stall_D),
        .stall_X       (stall_X),
        .squash_F      (squash_F),
        .squash_D      (squash_D),
        .op1_byp_sel_D (op1_byp_sel_D),
        .op2_byp_sel_D (op2_byp_sel_D),
        .rf_wen_W      (rf_wen_W),
        .rf_waddr_W    (rf_waddr_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [4:0] rd);
        return {20'd8, rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_jr(input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, 5'd0, 7'b1100111};
    endfunction
    function automatic logic [31:0] enc_bne(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b001, 5'd8, 7'b1100011};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, present a D instruction, settle.
    task automatic cyc(input logic [31:0] inst, input logic eq);
        @(negedge clk);
        inst_D = inst;
        eq_X   = eq;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cyc(NOP, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_stall_F"},  32'(stall_F),       32'd0);
        check_eq({tag, "_stall_D"},  32'(stall_D),       32'd0);
        check_eq({tag, "_stall_X"},  32'(stall_X),       32'd0);
        check_eq({tag, "_squash_F"}, 32'(squash_F),      32'd0);
        check_eq({tag, "_squash_D"}, 32'(squash_D),      32'd0);
        check_eq({tag, "_sel1"},     32'(op1_byp_sel_D), 32'd0);
        check_eq({tag, "_sel2"},     32'(op2_byp_sel_D), 32'd0);
        check_eq({tag, "_wen"},      32'(rf_wen_W),      32'd0);
        check_eq({tag, "_waddr"},    32'(rf_waddr_W),    32'd0);
    endtask

    initial begin
        rst    = 1'b0;
        inst_D = enc_bne(5'd1, 5'd2);
        eq_X   = 1'b0;
        #1;
        check_idle("rst_hold");
        @(negedge clk);
        inst_D = NOP;
        eq_X   = 1'b1;
        rst    = 1'b1;

        // ALU-to-ALU bypass
        cyc(enc_add(5'd1, 5'd0, 5'd0), 1'b1);
        check_eq("alu_first_sel1", 32'(op1_byp_sel_D), 32'd0);
        check_eq("alu_first_stall", 32'(stall_D), 32'd0);
        cyc(enc_add(5'd2, 5'd1, 5'd1), 1'b1);
        check_eq("alu_sel1", 32'(op1_byp_sel_D), 32'd1);
        check_eq("alu_sel2", 32'(op2_byp_sel_D), 32'd1);
        check_eq("alu_stall_F", 32'(stall_F), 32'd0);
        cyc(enc_add(5'd7, 5'd1, 5'd2), 1'b1);
        check_eq("alu_m_sel1", 32'(op1_byp_sel_D), 32'd2);
        check_eq("alu_x_sel2", 32'(op2_byp_sel_D), 32'd1);
        cyc(NOP, 1'b1);
        check_eq("alu_w_wen", 32'(rf_wen_W), 32'd1);
        check_eq("alu_w_addr", 32'(rf_waddr_W), 32'd1);
        cyc(NOP, 1'b1);
        check_eq("alu_w_addr2", 32'(rf_waddr_W), 32'd2);
        drain();

        // x0 never bypasses or stalls
        cyc(enc_add(5'd0, 5'd0, 5'd0), 1'b1);
        cyc(enc_add(5'd8, 5'd0, 5'd0), 1'b1);
        check_eq("x0_sel1", 32'(op1_byp_sel_D), 32'd0);
        check_eq("x0_sel2", 32'(op2_byp_sel_D), 32'd0);
        cyc(enc_lw(5'd0, 5'd0), 1'b1);
        cyc(enc_add(5'd9, 5'd0, 5'd0), 1'b1);
        check_eq("x0_lw_stall", 32'(stall_D), 32'd0);
        drain();

        // Load-use stall then bypass from M
        cyc(enc_lw(5'd3, 5'd0), 1'b1);
        cyc(enc_add(5'd4, 5'd3, 5'd0), 1'b1);
        check_eq("lu_stall_F", 32'(stall_F), 32'd1);
        check_eq("lu_stall_D", 32'(stall_D), 32'd1);
        check_eq("lu_squash_F", 32'(squash_F), 32'd0);
        cyc(enc_add(5'd4, 5'd3, 5'd0), 1'b1);
        check_eq("lu_release", 32'(stall_D), 32'd0);
        check_eq("lu_sel1", 32'(op1_byp_sel_D), 32'd2);
        check_eq("lu_sel2", 32'(op2_byp_sel_D), 32'd0);
        cyc(NOP, 1'b1);
        check_eq("lu_w_wen", 32'(rf_wen_W), 32'd1);
        check_eq("lu_w_addr", 32'(rf_waddr_W), 32'd3);
        cyc(NOP, 1'b1);
        check_eq("lu_bubble_wen", 32'(rf_wen_W), 32'd0);
        cyc(NOP, 1'b1);
        check_eq("lu_add_addr", 32'(rf_waddr_W), 32'd4);
        drain();

        // Taken branch in X
        cyc(enc_bne(5'd1, 5'd2), 1'b1);
        cyc(enc_add(5'd10, 5'd0, 5'd0), 1'b0);
        check_eq("br_squash_D", 32'(squash_D), 32'd1);
        check_eq("br_squash_F", 32'(squash_F), 32'd1);
        cyc(enc_add(5'd11, 5'd0, 5'd0), 1'b1);
        check_eq("br_next_sqD", 32'(squash_D), 32'd0);
        check_eq("br_next_sqF", 32'(squash_F), 32'd0);
        cyc(enc_add(5'd12, 5'd0, 5'd0), 1'b1);
        cyc(NOP, 1'b1);
        check_eq("br_bub1_wen", 32'(rf_wen_W), 32'd0);
        cyc(NOP, 1'b1);
        check_eq("br_bub2_wen", 32'(rf_wen_W), 32'd0);
        cyc(NOP, 1'b1);
        check_eq("br_add_wen", 32'(rf_wen_W), 32'd1);
        check_eq("br_add_addr", 32'(rf_waddr_W), 32'd12);
        drain();

        // JAL squashes F and writes its link register
        cyc(enc_jal(5'd1), 1'b1);
        check_eq("jal_squash_F", 32'(squash_F), 32'd1);
        check_eq("jal_squash_D", 32'(squash_D), 32'd0);
        cyc(enc_add(5'd13, 5'd0, 5'd0), 1'b1);
        check_eq("jal_next_sqF", 32'(squash_F), 32'd0);
        cyc(NOP, 1'b1);
        cyc(NOP, 1'b1);
        check_eq("jal_w_wen", 32'(rf_wen_W), 32'd1);
        check_eq("jal_w_addr", 32'(rf_waddr_W), 32'd1);
        drain();

        // JR stalled on a load does not squash until the stall clears
        cyc(enc_lw(5'd5, 5'd0), 1'b1);
        cyc(enc_jr(5'd5), 1'b1);
        check_eq("jr_stall_D", 32'(stall_D), 32'd1);
        check_eq("jr_hold_sqF", 32'(squash_F), 32'd0);
        cyc(enc_jr(5'd5), 1'b1);
        check_eq("jr_go_stall", 32'(stall_D), 32'd0);
        check_eq("jr_go_sqF", 32'(squash_F), 32'd1);
        check_eq("jr_sel1", 32'(op1_byp_sel_D), 32'd2);
        cyc(NOP, 1'b1);
        drain();

        // Reset mid-stream with a load in M
        cyc(enc_lw(5'd6, 5'd0), 1'b1);
        cyc(NOP, 1'b1);
        cyc(enc_add(5'd7, 5'd6, 5'd6), 1'b0);
        check_eq("mid_pre_sel1", 32'(op1_byp_sel_D), 32'd2);
        rst = 1'b0;
        #1;
        check_idle("mid_rst");
        cyc(enc_add(5'd7, 5'd6, 5'd6), 1'b0);
        check_idle("mid_rst_held");
        @(negedge clk);
        rst    = 1'b1;
        inst_D = NOP;
        eq_X   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(NOP, 1'b1);
            check_eq("post_rst_wen", 32'(rf_wen_W), 32'd0);
        end

`ifdef PROC_HAZARD_MUL_STALL_EN
        // Multi-cycle MUL holds X for MUL_LAT-1 cycles
        cyc(enc_mul(5'd5, 5'd1, 5'd2), 1'b1);
        cyc(enc_add(5'd6, 5'd5, 5'd0), 1'b1);
        check_eq("mul_stall_X1", 32'(stall_X), 32'd1);
        check_eq("mul_stall_D1", 32'(stall_D), 32'd1);
        cyc(enc_add(5'd6, 5'd5, 5'd0), 1'b1);
        check_eq("mul_stall_X2", 32'(stall_X), 32'd1);
        cyc(enc_add(5'd6, 5'd5, 5'd0), 1'b1);
        check_eq("mul_stall_X3", 32'(stall_X), 32'd0);
        check_eq("mul_stall_D3", 32'(stall_D), 32'd0);
        check_eq("mul_sel1", 32'(op1_byp_sel_D), 32'd1);
        cyc(NOP, 1'b1);
        check_eq("mul_bubble_wen", 32'(rf_wen_W), 32'd0);
        cyc(NOP, 1'b1);
        check_eq("mul_w_wen", 32'(rf_wen_W), 32'd1);
        check_eq("mul_w_addr", 32'(rf_waddr_W), 32'd5);
`else
        // MUL behaves like ADD
        cyc(enc_mul(5'd5, 5'd1, 5'd2), 1'b1);
        cyc(enc_add(5'd6, 5'd5, 5'd0), 1'b1);
        check_eq("mul_stall_X", 32'(stall_X), 32'd0);
        check_eq("mul_stall_D", 32'(stall_D), 32'd0);
        check_eq("mul_sel1", 32'(op1_byp_sel_D), 32'd1);
        cyc(NOP, 1'b1);
        cyc(NOP, 1'b1);
        check_eq("mul_w_wen", 32'(rf_wen_W), 32'd1);
        check_eq("mul_w_addr", 32'(rf_waddr_W), 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
